// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ps2_pkg                                                        |
// | Purpose : Shared constants, FSM state enum and event struct for the     |
// |           PS/2 scancode decoder.                                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package ps2_pkg;

    localparam logic [7:0] c_prefix_e0  = 8'hE0;
    localparam logic [7:0] c_prefix_f0  = 8'hF0;

    localparam logic [7:0] c_discard_00 = 8'h00;
    localparam logic [7:0] c_discard_ff = 8'hFF;
    localparam logic [7:0] c_discard_aa = 8'hAA;
    localparam logic [7:0] c_discard_fa = 8'hFA;
    localparam logic [7:0] c_discard_fe = 8'hFE;

    localparam logic [7:0] c_key_q = 8'h15;
    localparam logic [7:0] c_key_a = 8'h1C;
    localparam logic [7:0] c_key_w = 8'h1D;
    localparam logic [7:0] c_key_s = 8'h1B;
    localparam logic [7:0] c_key_e = 8'h24;
    localparam logic [7:0] c_key_d = 8'h23;
    localparam logic [7:0] c_key_r = 8'h2D;
    localparam logic [7:0] c_key_f = 8'h2B;
    localparam logic [7:0] c_key_t = 8'h2C;
    localparam logic [7:0] c_key_g = 8'h34;
    localparam logic [7:0] c_key_y = 8'h35;
    localparam logic [7:0] c_key_h = 8'h33;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_event_t;

    // Bytes the keyboard sends as status/acknowledge, never as key codes.
    function automatic logic is_discard(input logic [7:0] code);
        return (code == c_discard_00) || (code == c_discard_ff) ||
               (code == c_discard_aa) || (code == c_discard_fa) ||
               (code == c_discard_fe);
    endfunction

    function automatic logic [11:0] key_mask(input logic [7:0] code);
        logic [11:0] m;
        m = 12'd0;
        case (code)
            c_key_q: m[0]  = 1'b1;
            c_key_a: m[1]  = 1'b1;
            c_key_w: m[2]  = 1'b1;
            c_key_s: m[3]  = 1'b1;
            c_key_e: m[4]  = 1'b1;
            c_key_d: m[5]  = 1'b1;
            c_key_r: m[6]  = 1'b1;
            c_key_f: m[7]  = 1'b1;
            c_key_t: m[8]  = 1'b1;
            c_key_g: m[9]  = 1'b1;
            c_key_y: m[10] = 1'b1;
            c_key_h: m[11] = 1'b1;
            default: m = 12'd0;
        endcase
        return m;
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ps2_event_fifo                                                 |
// | Purpose : Synchronous event FIFO, valid/ready read side, full/empty.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  ps2_event_t i_data,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_rd_valid,
    input  logic       i_rd_ready,
    output ps2_event_t o_rd_data
);

    localparam int c_aw = $clog2(DEPTH);

    ps2_event_t        mem_q [DEPTH];
    logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_aw:0]     count_q,  count_d;
    logic              w_push;
    logic              w_pop;

    assign o_full     = (count_q == (c_aw+1)'(DEPTH));
    assign o_empty    = (count_q == '0);
    assign o_rd_valid = ~o_empty;
    // Head reads as zero while empty so outputs match the reset state.
    assign o_rd_data  = o_empty ? '0 : mem_q[rd_ptr_q];

    assign w_pop  = i_rd_ready & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule : ps2_event_fifo
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ps2_scancode_decoder                                           |
// | Purpose : PS/2 set-2 byte stream to press/release events with a held-   |
// |           key map. Define PS2_TYPEMATIC_FILTER_EN to drop repeats.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BYTE_VALID,
    input  logic [7:0]  BYTE_DATA,
    input  logic        BYTE_ERR,
    output logic        EV_VALID,
    input  logic        EV_READY,
    output logic [7:0]  EV_CODE,
    output logic        EV_BREAK,
    output logic        EV_EXT,
    output logic [11:0] HELD,
    output logic        OVERFLOW,
    output logic [7:0]  ERR_CNT
);

    localparam int c_tmo_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    ps2_state_e          state_q, state_d;
    logic [c_tmo_w-1:0]  tmo_q, tmo_d;
    logic                evt_valid_q, evt_valid_d;
    ps2_event_t          evt_q, evt_d;
    logic [11:0]         held_q, held_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic                w_err_inc;
    logic                w_emit;
    logic [11:0]         w_mask;
    logic                w_repeat;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_head_valid;
    ps2_event_t          w_head;

    // Decode stage: prefix FSM, timeout and error accounting.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        evt_valid_d = 1'b0;
        evt_d       = evt_q;
        w_err_inc   = 1'b0;
        w_emit      = 1'b0;
        if (BYTE_VALID) begin
            tmo_d = '0;
            if (BYTE_ERR) begin
                state_d   = ST_IDLE;
                w_err_inc = 1'b1;
            end else if (is_discard(BYTE_DATA)) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (BYTE_DATA == c_prefix_e0) begin
                            state_d = ST_GOT_E0;
                        end else if (BYTE_DATA == c_prefix_f0) begin
                            state_d = ST_GOT_F0;
                        end else begin
                            w_emit = 1'b1;
                        end
                    end
                    ST_GOT_E0: begin
                        if (BYTE_DATA == c_prefix_f0) begin
                            state_d = ST_GOT_E0F0;
                        end else if (BYTE_DATA == c_prefix_e0) begin
                            state_d   = ST_IDLE;
                            w_err_inc = 1'b1;
                        end else begin
                            w_emit = 1'b1;
                        end
                    end
                    default: begin
                        if ((BYTE_DATA == c_prefix_e0) || (BYTE_DATA == c_prefix_f0)) begin
                            state_d   = ST_IDLE;
                            w_err_inc = 1'b1;
                        end else begin
                            w_emit = 1'b1;
                        end
                    end
                endcase
                if (w_emit) begin
                    state_d     = ST_IDLE;
                    evt_valid_d = 1'b1;
                    evt_d.code  = BYTE_DATA;
                    evt_d.brk   = (state_q == ST_GOT_F0) || (state_q == ST_GOT_E0F0);
                    evt_d.ext   = (state_q == ST_GOT_E0) || (state_q == ST_GOT_E0F0);
                end
            end
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == c_tmo_w'(TIMEOUT_CYC - 1)) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Commit stage: FIFO push, held-key map, overflow and error counter.
    always_comb begin
        w_mask = key_mask(evt_q.code) & {12{~evt_q.ext}};
`ifdef PS2_TYPEMATIC_FILTER_EN
        w_repeat = ~evt_q.brk & (|(w_mask & held_q));
`else
        w_repeat = 1'b0;
`endif
        w_push = evt_valid_q & ~w_repeat;
        w_pop  = w_head_valid & EV_READY;

        held_d = held_q;
        if (evt_valid_q) begin
            held_d = evt_q.brk ? (held_q & ~w_mask) : (held_q | w_mask);
        end

        ovf_d = ovf_q | (w_push & w_full & ~w_pop);

        err_cnt_d = err_cnt_q;
        if (w_err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_q       <= '0;
            held_q      <= '0;
            ovf_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            evt_valid_q <= evt_valid_d;
            evt_q       <= evt_d;
            held_q      <= held_d;
            ovf_q       <= ovf_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst        (RST),
        .i_push     (w_push),
        .i_data     (evt_q),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_rd_valid (w_head_valid),
        .i_rd_ready (EV_READY),
        .o_rd_data  (w_head)
    );

    assign EV_VALID = w_head_valid & ~w_empty;
    assign EV_CODE  = w_head.code;
    assign EV_BREAK = w_head.brk;
    assign EV_EXT   = w_head.ext;
    assign HELD     = held_q;
    assign OVERFLOW = ovf_q;
    assign ERR_CNT  = err_cnt_q;

endmodule : ps2_scancode_decoder
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_ps2_scancode_decoder                                        |
// | Purpose : Directed self-checking bench for ps2_scancode_decoder.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ps2_scancode_decoder;

    localparam int c_depth   = 4;
    localparam int c_timeout = 20;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_err;
    logic        ev_valid;
    logic        ev_ready;
    logic [7:0]  ev_code;
    logic        ev_break;
    logic        ev_ext;
    logic [11:0] held;
    logic        overflow;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ps2_scancode_decoder #(
        .FIFO_DEPTH  (c_depth),
        .TIMEOUT_CYC (c_timeout)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .BYTE_VALID (byte_valid),
        .BYTE_DATA  (byte_data),
        .BYTE_ERR   (byte_err),
        .EV_VALID   (ev_valid),
        .EV_READY   (ev_ready),
        .EV_CODE    (ev_code),
        .EV_BREAK   (ev_break),
        .EV_EXT     (ev_ext),
        .HELD       (held),
        .OVERFLOW   (overflow),
        .ERR_CNT    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        byte_valid = 1'b1;
        byte_data  = b;
        byte_err   = err;
        tick();
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Head event packed as {valid, code, break, ext}.
    function automatic logic [10:0] head();
        return {ev_valid, ev_code, ev_break, ev_ext};
    endfunction

    initial begin
        rst        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_err   = 1'b0;
        ev_ready   = 1'b0;
        do_reset();

        check_value("reset_head",  head(),   {1'b0, 8'h00, 1'b0, 1'b0});
        check_value("reset_held",  held,     12'h000);
        check_value("reset_ovf",   overflow, 1'b0);
        check_value("reset_err",   err_cnt,  8'd0);

        // Single make code, latency of two edges.
        send_byte(8'h1C, 1'b0);
        check_value("press_a_lat1", ev_valid, 1'b0);
        tick();
        check_value("press_a_ev",   head(), {1'b1, 8'h1C, 1'b0, 1'b0});
        check_value("press_a_held", held,   12'h002);
        tick();
        check_value("press_a_stable", head(), {1'b1, 8'h1C, 1'b0, 1'b0});
        pop_one();
        check_value("press_a_popped", ev_valid, 1'b0);

        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        tick();
        check_value("rel_a_ev",   head(), {1'b1, 8'h1C, 1'b1, 1'b0});
        check_value("rel_a_held", held,   12'h000);
        pop_one();

        // Extended release of a key outside the held set.
        send_byte(8'h1D, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        tick();
        check_value("press_w_ev", head(), {1'b1, 8'h1D, 1'b0, 1'b0});
        pop_one();
        check_value("ext_rel_ev",   head(), {1'b1, 8'h75, 1'b1, 1'b1});
        check_value("ext_rel_held", held,   12'h004);
        pop_one();
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1D, 1'b0);
        tick();
        pop_one();
        check_value("rel_w_held", held, 12'h000);

        // Frame error after a break prefix abandons the sequence.
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b1);
        tick();
        tick();
        check_value("frame_err_noev", ev_valid, 1'b0);
        check_value("frame_err_cnt",  err_cnt,  8'd1);
        send_byte(8'h15, 1'b0);
        tick();
        check_value("after_err_ev",   head(), {1'b1, 8'h15, 1'b0, 1'b0});
        check_value("after_err_held", held,   12'h001);
        pop_one();

        // Double prefix is a protocol error; status bytes are silently dropped.
        send_byte(8'hF0, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hFA, 1'b0);
        tick();
        tick();
        check_value("proto_err_noev", ev_valid, 1'b0);
        check_value("proto_err_cnt",  err_cnt,  8'd2);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hE0, 1'b0);
        tick();
        check_value("e0e0_err_cnt", err_cnt, 8'd3);

        // Five presses into a depth-4 FIFO with no consumer; Q is already held.
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1D, 1'b0);
        send_byte(8'h1B, 1'b0);
        send_byte(8'h24, 1'b0);
        send_byte(8'h23, 1'b0);
        tick();
        tick();
        check_value("full_ovf",  overflow, 1'b1);
        check_value("full_held", held,     12'h03F);
        check_value("q0", head(), {1'b1, 8'h1C, 1'b0, 1'b0});
        pop_one();
        check_value("q1", head(), {1'b1, 8'h1D, 1'b0, 1'b0});
        pop_one();
        check_value("q2", head(), {1'b1, 8'h1B, 1'b0, 1'b0});
        pop_one();
        check_value("q3", head(), {1'b1, 8'h24, 1'b0, 1'b0});
        pop_one();
        check_value("q_empty", ev_valid, 1'b0);
        pop_one();
        check_value("q_empty_pop", ev_valid, 1'b0);
        check_value("ovf_sticky",  overflow, 1'b1);

        // Typematic repeat of the held Q key.
        send_byte(8'h15, 1'b0);
        tick();
`ifdef PS2_TYPEMATIC_FILTER_EN
        check_value("repeat_ev", ev_valid, 1'b0);
`else
        check_value("repeat_ev", head(), {1'b1, 8'h15, 1'b0, 1'b0});
        pop_one();
`endif
        check_value("repeat_held", held, 12'h03F);

        do_reset();
        check_value("rst2_held", held,     12'h000);
        check_value("rst2_ovf",  overflow, 1'b0);
        check_value("rst2_err",  err_cnt,  8'd0);

        // Prefix expires after exactly the timeout length of idle cycles.
        send_byte(8'hE0, 1'b0);
        repeat (c_timeout) tick();
        send_byte(8'h1D, 1'b0);
        tick();
        check_value("timeout_ev",  head(),  {1'b1, 8'h1D, 1'b0, 1'b0});
        check_value("timeout_err", err_cnt, 8'd0);
        pop_one();

        // One cycle short of the timeout the prefix still applies.
        send_byte(8'hE0, 1'b0);
        repeat (c_timeout - 1) tick();
        send_byte(8'h74, 1'b0);
        tick();
        check_value("pre_timeout_ev", head(), {1'b1, 8'h74, 1'b0, 1'b1});
        pop_one();

        // Byte presented during reset is ignored.
        rst        = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h15;
        tick();
        rst        = 1'b0;
        byte_valid = 1'b0;
        tick();
        tick();
        check_value("rst_byte_ev",   ev_valid, 1'b0);
        check_value("rst_byte_held", held,     12'h000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ps2_scancode_decoder
`default_nettype wire
